// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-to-one I/D cache arbiter for a shared slow_memory port (ARB_RR_EN selects round-robin ties)
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read_I,
  input  logic               mem_write_I,
  input  logic [27:0]        mem_addr_I,
  input  logic [127:0]       mem_wdata_I,
  output logic [127:0]       mem_rdata_I,
  output logic               mem_ready_I,
  input  logic               mem_read_D,
  input  logic               mem_write_D,
  input  logic [27:0]        mem_addr_D,
  input  logic [127:0]       mem_wdata_D,
  output logic [127:0]       mem_rdata_D,
  output logic               mem_ready_D,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_addr,
  output logic [127:0]       mem_wdata,
  input  logic [127:0]       mem_rdata,
  input  logic               mem_ready,
  output logic [CNT_W-1:0]   wait_cnt_I,
  output logic [CNT_W-1:0]   wait_cnt_D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;

  logic req_i;
  logic req_d;
  logic tie_to_i;

  assign req_i = mem_read_I | mem_write_I;
  assign req_d = mem_read_D | mem_write_D;

  // Read data is broadcast; each cache qualifies it with its own ready.
  assign mem_rdata_I = mem_rdata;
  assign mem_rdata_D = mem_rdata;

`ifdef ARB_RR_EN
  logic last_i;

  // A tie goes to whichever cache did not own the port most recently.
  assign tie_to_i = ~last_i;

  // Remember the owner on every entry into a grant state; reset favours D next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_i <= 1'b1;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_i <= (state_nxt == GNT_I);
    end
  end
`else
  // Fixed priority: D always wins a tie.
  assign tie_to_i = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and memory-side muxing for the current owner.
  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 28'd0;
    mem_wdata   = 128'd0;
    mem_ready_I = 1'b0;
    mem_ready_D = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          state_nxt = tie_to_i ? GNT_I : GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end else if (req_d) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        mem_read    = mem_read_I;
        mem_write   = mem_write_I;
        mem_addr    = mem_addr_I;
        mem_wdata   = mem_wdata_I;
        mem_ready_I = mem_ready;
        if (mem_ready) begin
          state_nxt = GAP;
        end else if (!req_i) begin
          state_nxt = IDLE;
        end
      end
      GNT_D: begin
        mem_read    = mem_read_D;
        mem_write   = mem_write_D;
        mem_addr    = mem_addr_D;
        mem_wdata   = mem_wdata_D;
        mem_ready_D = mem_ready;
        if (mem_ready) begin
          state_nxt = GAP;
        end else if (!req_d) begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Saturating wait counters: a cycle spent requesting without owning the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_I <= '0;
      wait_cnt_D <= '0;
    end else begin
      if (req_i && state != GNT_I && wait_cnt_I != CNT_MAX) begin
        wait_cnt_I <= wait_cnt_I + CNT_ONE;
      end
      if (req_d && state != GNT_D && wait_cnt_D != CNT_MAX) begin
        wait_cnt_D <= wait_cnt_D + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-rule reference model
module tb_mem_arbiter;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read_I, mem_write_I;
  logic [27:0]      mem_addr_I;
  logic [127:0]     mem_wdata_I;
  logic [127:0]     mem_rdata_I;
  logic             mem_ready_I;
  logic             mem_read_D, mem_write_D;
  logic [27:0]      mem_addr_D;
  logic [127:0]     mem_wdata_D;
  logic [127:0]     mem_rdata_D;
  logic             mem_ready_D;
  logic             mem_read, mem_write;
  logic [27:0]      mem_addr;
  logic [127:0]     mem_wdata;
  logic [127:0]     mem_rdata;
  logic             mem_ready;
  logic [CNT_W-1:0] wait_cnt_I, wait_cnt_D;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: who owns the port, whether the boundary cycle is pending
  int m_owner;   // 0 none, 1 I, 2 D
  bit m_gap;
  bit m_last_i;
  int m_cnt_i, m_cnt_d;

  always #5 clk = ~clk;

  mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
    .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
    .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
    .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wait_cnt_I(wait_cnt_I), .wait_cnt_D(wait_cnt_D)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_I = 0; mem_write_I = 0; mem_addr_I = '0; mem_wdata_I = '0;
    mem_read_D = 0; mem_write_D = 0; mem_addr_D = '0; mem_wdata_D = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mem_read_I = 1; mem_addr_I = 28'($urandom); mem_wdata_I = rnd128();
    mem_write_D = 1; mem_addr_D = 28'($urandom); mem_wdata_D = rnd128();
    mem_ready = 1; mem_rdata = rnd128();
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_req got=%b exp=00", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin n_bad++; $display("FAIL reset_addr_data got=%h/%h exp=0", mem_addr, mem_wdata); end
    n_cmp++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b exp=00", {mem_ready_I, mem_ready_D}); end
    n_cmp++; if (wait_cnt_I !== '0 || wait_cnt_D !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", wait_cnt_I, wait_cnt_D); end
    tick();
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_single_i_read();
    do_reset();
    mem_read_I = 1; mem_addr_I = 28'h0000010;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL single_idle_read got=%b exp=0", mem_read); end
    tick();
    for (int k = 1; k <= 5; k++) begin
      mem_ready = (k == 5);
      mem_rdata = (k == 5) ? PAT_A5 : rnd128();
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) begin n_bad++; $display("FAIL single_grant got=%b/%h exp=1/0000010", mem_read, mem_addr); end
        n_cmp++; if (wait_cnt_I !== 4'd1) begin n_bad++; $display("FAIL single_wait got=%0d exp=1", wait_cnt_I); end
      end
      n_cmp++; if (mem_ready_I !== (k == 5) || mem_ready_D !== 1'b0) begin n_bad++; $display("FAIL single_ready k=%0d got=%b%b exp=%b0", k, mem_ready_I, mem_ready_D, (k == 5)); end
      if (k == 5) begin
        n_cmp++; if (mem_rdata_I !== PAT_A5) begin n_bad++; $display("FAIL single_rdata got=%h exp=%h", mem_rdata_I, PAT_A5); end
      end
      tick();
    end
    mem_ready = 0;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0 || mem_addr !== 28'd0) begin n_bad++; $display("FAIL single_gap got=%b/%h exp=0/0", mem_read, mem_addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_tie();
    logic [27:0]  a_i, a_d, a_d2, win_addr, lose_addr;
    logic [127:0] w_d;
    a_i = 28'($urandom); a_d = 28'($urandom); a_d2 = 28'($urandom); w_d = rnd128();
    do_reset();
    mem_read_I = 1; mem_addr_I = a_i;
    mem_write_D = 1; mem_addr_D = a_d; mem_wdata_D = w_d;
    tick();
    for (int k = 1; k <= 5; k++) begin
      mem_ready = (k == 5);
      @(negedge clk);
      if (k == 1) begin
        n_cmp++; if ({mem_read, mem_write} !== 2'b01 || mem_addr !== a_d || mem_wdata !== w_d) begin n_bad++; $display("FAIL tie_first_d got=%b%b/%h exp=01/%h", mem_read, mem_write, mem_addr, a_d); end
      end
      n_cmp++; if (mem_ready_D !== (k == 5) || mem_ready_I !== 1'b0) begin n_bad++; $display("FAIL tie_ready_d k=%0d got=%b%b exp=0%b", k, mem_ready_I, mem_ready_D, (k == 5)); end
      tick();
    end
    // D re-requests immediately so the next IDLE sees a second tie
    mem_ready = 0; mem_write_D = 0; mem_read_D = 1; mem_addr_D = a_d2;
    @(negedge clk);
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL tie_gap got=%b exp=00", {mem_read, mem_write}); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL tie_idle got=%b exp=0", mem_read); end
    tick();
    win_addr  = RR ? a_i : a_d2;
    lose_addr = RR ? a_d2 : a_i;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== win_addr) begin n_bad++; $display("FAIL tie_second got=%b/%h exp=1/%h", mem_read, mem_addr, win_addr); end
    n_cmp++; if (wait_cnt_I !== 4'd8) begin n_bad++; $display("FAIL tie_wait_i got=%0d exp=8", wait_cnt_I); end
    n_cmp++; if (wait_cnt_D !== 4'd3) begin n_bad++; $display("FAIL tie_wait_d got=%0d exp=3", wait_cnt_D); end
    tick();
    mem_ready = 1;
    @(negedge clk);
    n_cmp++; if ({mem_ready_I, mem_ready_D} !== (RR ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL tie_second_ready got=%b%b exp=%b", mem_ready_I, mem_ready_D, (RR ? 2'b10 : 2'b01)); end
    tick();
    mem_ready = 0;
    if (RR) mem_read_I = 0; else mem_read_D = 0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== lose_addr) begin n_bad++; $display("FAIL tie_loser got=%b/%h exp=1/%h", mem_read, mem_addr, lose_addr); end
    tick();
    idle_inputs();
  endtask

  task automatic test_stream();
    int order[$];
    int done_i, done_d, exp_who;
    bit got_i, got_d;
    done_i = 0; done_d = 0;
    do_reset();
    mem_read_I = 1; mem_addr_I = 28'($urandom);
    mem_write_D = 1; mem_addr_D = 28'($urandom); mem_wdata_D = rnd128();
    for (int cyc = 0; cyc < 300 && (done_i < 4 || done_d < 4); cyc++) begin
      mem_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n_cmp++; if (mem_ready_I && mem_ready_D) begin n_bad++; $display("FAIL stream_dual_ready cyc=%0d got=11 exp=not 11", cyc); end
      n_cmp++; if (mem_read && mem_write) begin n_bad++; $display("FAIL stream_mixed_owner cyc=%0d got=rd1 wr1 exp=one", cyc); end
      got_i = mem_ready_I; got_d = mem_ready_D;
      tick();
      if (got_i) begin
        order.push_back(1); done_i++;
        if (done_i == 4) mem_read_I = 0; else mem_addr_I = 28'($urandom);
      end
      if (got_d) begin
        order.push_back(2); done_d++;
        if (done_d == 4) mem_write_D = 0; else mem_addr_D = 28'($urandom);
      end
    end
    n_cmp++; if (order.size() != 8) begin n_bad++; $display("FAIL stream_count got=%0d exp=8", order.size()); end
    for (int k = 0; k < 8 && k < order.size(); k++) begin
      exp_who = RR ? ((k % 2 == 0) ? 2 : 1) : ((k < 4) ? 2 : 1);
      n_cmp++; if (order[k] != exp_who) begin n_bad++; $display("FAIL stream_order k=%0d got=%0d exp=%0d", k, order[k], exp_who); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_grant();
    logic [27:0] a_i;
    a_i = 28'($urandom);
    do_reset();
    mem_write_D = 1; mem_addr_D = 28'($urandom); mem_wdata_D = rnd128();
    tick();
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant got=%b exp=1", mem_write); end
    tick();
    rst_n = 0; mem_read_I = 1; mem_addr_I = a_i;
    @(negedge clk);
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL rstmid_hold got=%b exp=1", mem_write); end
    tick();
    rst_n = 1; mem_write_D = 0;
    @(negedge clk);
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL rstmid_drop got=%b exp=00", {mem_read, mem_write}); end
    n_cmp++; if (wait_cnt_I !== '0 || wait_cnt_D !== '0) begin n_bad++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", wait_cnt_I, wait_cnt_D); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== a_i) begin n_bad++; $display("FAIL rstmid_regrant got=%b/%h exp=1/%h", mem_read, mem_addr, a_i); end
    tick();
    idle_inputs();
  endtask

  task automatic test_abort();
    logic [27:0] a_i, a_d;
    a_i = 28'($urandom); a_d = 28'($urandom);
    do_reset();
    mem_read_D = 1; mem_addr_D = a_d;
    tick();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== a_d) begin n_bad++; $display("FAIL abort_grant got=%b/%h exp=1/%h", mem_read, mem_addr, a_d); end
    tick();
    mem_read_D = 0; mem_read_I = 1; mem_addr_I = a_i;
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL abort_drop got=%b exp=0", mem_read); end
    tick();
    mem_ready = 1;
    @(negedge clk);
    n_cmp++; if ({mem_ready_I, mem_ready_D, mem_read} !== 3'b000) begin n_bad++; $display("FAIL abort_idle got=%b exp=000", {mem_ready_I, mem_ready_D, mem_read}); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== a_i || {mem_ready_I, mem_ready_D} !== 2'b10) begin n_bad++; $display("FAIL abort_next got=%b/%h/%b%b exp=1/%h/10", mem_read, mem_addr, mem_ready_I, mem_ready_D, a_i); end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic [27:0] a_d;
    a_d = 28'($urandom);
    do_reset();
    mem_read_I = 1; mem_addr_I = 28'($urandom);
    mem_read_D = 1; mem_addr_D = a_d;
    tick();
    for (int k = 0; k < 25; k++) tick();
    @(negedge clk);
    n_cmp++; if (wait_cnt_I !== 4'hF) begin n_bad++; $display("FAIL sat_cnt_i got=%h exp=f", wait_cnt_I); end
    n_cmp++; if (wait_cnt_D !== 4'd1) begin n_bad++; $display("FAIL sat_cnt_d got=%0d exp=1", wait_cnt_D); end
    n_cmp++; if (mem_read !== 1'b1 || mem_addr !== a_d) begin n_bad++; $display("FAIL sat_owner got=%b/%h exp=1/%h", mem_read, mem_addr, a_d); end
    tick();
    mem_ready = 1;
    @(negedge clk);
    n_cmp++; if (mem_ready_D !== 1'b1) begin n_bad++; $display("FAIL sat_ready got=%b exp=1", mem_ready_D); end
    tick();
    idle_inputs();
  endtask

  task automatic model_step();
    bit ri, rd;
    int win;
    if (!rst_n) begin
      m_owner = 0; m_gap = 0; m_last_i = 1; m_cnt_i = 0; m_cnt_d = 0;
    end else begin
      ri = mem_read_I | mem_write_I;
      rd = mem_read_D | mem_write_D;
      if (ri && m_owner != 1 && m_cnt_i < CMAX) m_cnt_i++;
      if (rd && m_owner != 2 && m_cnt_d < CMAX) m_cnt_d++;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_owner == 0) begin
        if (ri && rd) win = RR ? (m_last_i ? 2 : 1) : 2;
        else if (ri) win = 1;
        else if (rd) win = 2;
        else win = 0;
        m_owner = win;
        if (win != 0) m_last_i = (win == 1);
      end else if (mem_ready) begin
        m_owner = 0; m_gap = 1;
      end else if ((m_owner == 1 && !ri) || (m_owner == 2 && !rd)) begin
        m_owner = 0;
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]   e_rw;
    logic [27:0]  e_addr;
    logic [127:0] e_wdata;
    logic [1:0]   e_rdy;
    bit got_i, got_d;
    do_reset();
    m_owner = 0; m_gap = 0; m_last_i = 1; m_cnt_i = 0; m_cnt_d = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = rnd128();
      if (!(mem_read_I | mem_write_I)) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) mem_read_I = 1; else mem_write_I = 1;
          mem_addr_I = 28'($urandom); mem_wdata_I = rnd128();
        end
      end else if ($urandom_range(0, 49) == 0) begin
        mem_read_I = 0; mem_write_I = 0;
      end
      if (!(mem_read_D | mem_write_D)) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) mem_read_D = 1; else mem_write_D = 1;
          mem_addr_D = 28'($urandom); mem_wdata_D = rnd128();
        end
      end else if ($urandom_range(0, 49) == 0) begin
        mem_read_D = 0; mem_write_D = 0;
      end
      @(negedge clk);
      e_rw = 2'b00; e_addr = '0; e_wdata = '0; e_rdy = 2'b00;
      if (m_owner == 1) begin
        e_rw = {mem_read_I, mem_write_I}; e_addr = mem_addr_I; e_wdata = mem_wdata_I; e_rdy = {mem_ready, 1'b0};
      end else if (m_owner == 2) begin
        e_rw = {mem_read_D, mem_write_D}; e_addr = mem_addr_D; e_wdata = mem_wdata_D; e_rdy = {1'b0, mem_ready};
      end
      n_cmp++; if ({mem_read, mem_write} !== e_rw) begin n_bad++; $display("FAIL rand_rw c=%0d got=%b exp=%b", c, {mem_read, mem_write}, e_rw); end
      n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL rand_addr c=%0d got=%h exp=%h", c, mem_addr, e_addr); end
      n_cmp++; if (mem_wdata !== e_wdata) begin n_bad++; $display("FAIL rand_wdata c=%0d got=%h exp=%h", c, mem_wdata, e_wdata); end
      n_cmp++; if ({mem_ready_I, mem_ready_D} !== e_rdy) begin n_bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, {mem_ready_I, mem_ready_D}, e_rdy); end
      n_cmp++; if (mem_rdata_I !== mem_rdata || mem_rdata_D !== mem_rdata) begin n_bad++; $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h", c, mem_rdata_I, mem_rdata_D, mem_rdata); end
      n_cmp++; if (wait_cnt_I !== CNT_W'(m_cnt_i)) begin n_bad++; $display("FAIL rand_cnt_i c=%0d got=%0d exp=%0d", c, wait_cnt_I, m_cnt_i); end
      n_cmp++; if (wait_cnt_D !== CNT_W'(m_cnt_d)) begin n_bad++; $display("FAIL rand_cnt_d c=%0d got=%0d exp=%0d", c, wait_cnt_D, m_cnt_d); end
      got_i = e_rdy[1]; got_d = e_rdy[0];
      @(posedge clk);
      model_step();
      #1;
      if (got_i) begin mem_read_I = 0; mem_write_I = 0; end
      if (got_d) begin mem_read_D = 0; mem_write_D = 0; end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_i_read();
    test_tie();
    test_stream();
    test_reset_mid_grant();
    test_abort();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
